// File: rtl/inv_sub_bytes_iter_if.sv
// rtl/inv_sub_bytes_iter_if.sv - handshake bundle for the iterative InvSubBytes engine
//
// Purpose: groups the input stream, output stream and status of inv_sub_bytes_iter.
// Signals:
//   in_valid  / in_ready  / in_data   input state handshake, byte i = in_data[8i+7:8i]
//   out_valid / out_ready / out_data  result handshake, same byte ordering
//   busy                              engine is in CALC or DONE
// Modports: master = upstream/downstream side, slave = the engine.
interface inv_sub_bytes_iter_if #(
    parameter int N_BYTES = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [8*N_BYTES-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*N_BYTES-1:0]   out_data;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative arithmetic AES inverse S-box over a full state
//
// Purpose: applies InvSubBytes to N_BYTES lanes in parallel. Each lane first takes the
// inverse affine transform of its byte, then raises the result to the 254th power in
// GF(2^8) (the multiplicative inverse, 0 -> 0) over 7 square-and-multiply cycles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, overrides everything
//   bus  inv_sub_bytes_iter_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy
module inv_sub_bytes_iter #(
    parameter int N_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_sub_bytes_iter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // s walks s0^(2^k); r accumulates s0^(2^1 + ... + 2^k). After 7 steps r = s0^254.
    logic [N_BYTES-1:0][7:0] s_q;
    logic [N_BYTES-1:0][7:0] r_q;
    logic [N_BYTES-1:0][7:0] s_sq;
    logic [N_BYTES-1:0][7:0] r_mul;
    logic [N_BYTES-1:0][7:0] aff;
    logic [2:0]              cnt_q;

    logic load;
    logic step;
    logic finish;
    logic ack;

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Inverse of the forward S-box affine map
    function automatic logic [7:0] invaff(input logic [7:0] y);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k] = y[(k + 2) % 8] ^ y[(k + 5) % 8] ^ y[(k + 7) % 8];
        end
        return b ^ 8'h05;
    endfunction

    always_comb begin
        for (int i = 0; i < N_BYTES; i++) begin
            aff[i]   = invaff(bus.in_data[8*i +: 8]);
            s_sq[i]  = gmul(s_q[i], s_q[i]);
            r_mul[i] = gmul(r_q[i], s_sq[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        finish       = 1'b0;
        ack          = 1'b0;
        case (state)
            IDLE: begin
                // Never advertise readiness while reset is being applied
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                step     = 1'b1;
                if (cnt_q == 3'd6) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                if (bus.out_ready) begin
                    ack        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q           <= '0;
            r_q           <= '0;
            cnt_q         <= 3'd0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < N_BYTES; i++) begin
                    s_q[i] <= aff[i];
                    r_q[i] <= 8'h01;
                end
                cnt_q <= 3'd0;
            end
            if (step) begin
                s_q   <= s_sq;
                r_q   <= r_mul;
                cnt_q <= cnt_q + 3'd1;
            end
            if (finish) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= r_mul;
            end
            // out_data is deliberately left holding the last result after the handshake
            if (ack) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - directed self-checking bench for inv_sub_bytes_iter
module tb_inv_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_sub_bytes_iter_if #(.N_BYTES(16)) bus ();

    inv_sub_bytes_iter #(.N_BYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] sbox_t [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Block b, lane i carries sbox(16b+i); its inverse is simply 16b+i
    function automatic logic [127:0] blk_in(input int b);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = sbox_t[16*b + i];
        return v;
    endfunction

    function automatic logic [127:0] blk_exp(input int b);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(16*b + i);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the acceptance edge
    task automatic accept(input logic [127:0] d, output int t_acc);
        logic got;
        got = 1'b0;
        t_acc = -1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus.in_ready) begin
                got = 1'b1;
                t_acc = cyc + 1;
            end else begin
                @(negedge clk);
            end
        end
        check("accept", 128'(got), 128'd1);
        @(negedge clk);
    endtask

    task automatic wait_out(output int t_out);
        logic got;
        got = 1'b0;
        t_out = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                t_out = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("out_valid_seen", 128'(got), 128'd1);
    endtask

    int ta;
    int to;
    int h;
    int prev;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;

        // Reset
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // Single block with latency and one-cycle valid pulse
        bus.out_ready = 1'b1;
        accept(128'h637c777bf26b6fc53001672bfed7ab76, ta);
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        check("t1_busy", 128'(bus.busy), 128'd1);
        wait_out(to);
        check("t1_latency", 128'(to - ta), 128'd7);
        check("t1_data", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);
        @(negedge clk);
        check("t1_pulse", 128'(bus.out_valid), 128'd0);
        check("t1_hold", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);

        // Boundary bytes
        accept(128'h63636363636363636363637ced160063, ta);
        bus.in_valid = 1'b0;
        wait_out(to);
        check("bnd_data", bus.out_data, 128'h000000000000000000000001_53ff5200);
        @(negedge clk);

        // Backpressure with a second state waiting
        bus.out_ready = 1'b0;
        accept(blk_in(1), ta);
        bus.in_valid = 1'b1;
        bus.in_data  = blk_in(2);
        wait_out(to);
        check("bp_data", bus.out_data, blk_exp(1));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.out_valid), 128'd1);
            check("bp_hold", bus.out_data, blk_exp(1));
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        h = cyc + 1;
        @(negedge clk);
        check("bp_idle_ready", 128'(bus.in_ready), 128'd1);
        check("bp_idle_valid", 128'(bus.out_valid), 128'd0);
        accept(blk_in(2), ta);
        check("bp_next_accept", 128'(ta - h), 128'd1);
        bus.in_valid = 1'b0;
        wait_out(to);
        check("bp_second", bus.out_data, blk_exp(2));
        @(negedge clk);

        // Reset three edges after acceptance
        accept(blk_in(3), ta);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 128'(bus.busy), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_busy_clr", 128'(bus.busy), 128'd0);
        check("mid_valid", 128'(bus.out_valid), 128'd0);
        check("mid_data", bus.out_data, 128'd0);
        check("mid_in_ready", 128'(bus.in_ready), 128'd1);
        accept(blk_in(3), ta);
        bus.in_valid = 1'b0;
        wait_out(to);
        check("mid_fresh", bus.out_data, blk_exp(3));
        @(negedge clk);

        // All 256 bytes, back-to-back with in_valid and out_ready high
        bus.out_ready = 1'b1;
        prev = -1;
        for (int b = 0; b < 16; b++) begin
            accept(blk_in(b), ta);
            if (b == 15) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_data = blk_in(b + 1);
            end
            if (b > 0) check("b2b_spacing", 128'(ta - prev), 128'd9);
            prev = ta;
            wait_out(to);
            check($sformatf("exh_blk%0d", b), bus.out_data, blk_exp(b));
        end
        repeat (3) @(negedge clk);
        check("end_idle", 128'(bus.busy), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative InvSubBytes engine for the AES-256 decryption datapath. It is the inverse of the forward byte-substitution table used on the encrypt side.
- Applies the AES inverse S-box to all bytes of a 128-bit state in parallel.
- Computes the inverse S-box arithmetically: inverse affine transform, then the GF(2^8) multiplicative inverse as x^254 by repeated squaring/multiplication over 7 cycles. No 256-entry table.
- Sits between InvShiftRows and AddRoundKey in the inverse round, with valid/ready handshakes on both sides.

Parameters:
- N_BYTES, 16, number of byte lanes processed in parallel (state width = 8*N_BYTES).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept a state
- in_data  in  8*N_BYTES  input state; byte i = in_data[8i+7:8i]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  8*N_BYTES  InvSubBytes(in_data), same byte ordering
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset:
  - Synchronous, active-high; `rst` wins over every other event.
  - State=IDLE, out_valid=0, out_data=0, busy=0, internal s/r/cnt=0.
  - in_ready=0 while rst=1.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready edge (acceptance edge E0), per lane load:
    - s <= invaff(in_byte)
    - r <= 8'h01
    - cnt <= 0
  - Go to CALC.
- invaff(y):
  - b'_k = y[(k+2)%8] ^ y[(k+5)%8] ^ y[(k+7)%8], then XOR 8'h05.
  - Purely combinational on the input.
- CALC:
  - in_ready=0. Each edge, per lane: s <= gmul(s,s); r <= gmul(r, gmul(s,s)); cnt <= cnt+1.
  - After the 7th CALC edge (cnt==6 at that edge): go to DONE, out_valid<=1, out_data<=updated r.
  - Result r = s0^254 = s0^-1; 0 maps to 0 with no special case.
- gmul: GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11B), combinational, 8-bit in/out.
- DONE:
  - out_valid=1; out_data held stable until handshake.
  - On out_valid&out_ready edge: out_valid<=0, go to IDLE.
  - No input accepted in DONE.
- Timing:
  - Latency: out_valid rises 7 edges after E0.
  - Minimum spacing between acceptances is 9 cycles with out_ready held high.
- Backpressure: out_ready low holds DONE indefinitely; out_data and out_valid stay stable.
- in_valid in CALC/DONE is ignored; upstream must hold it per the valid/ready rule.
- in_data is sampled only at E0; later changes have no effect.
- Reset mid-CALC or mid-DONE aborts the operation: next cycle is IDLE with out_valid=0, and no partial result is emitted.
- out_data is not cleared on handshake; it retains the last result until the next DONE or reset.

Test Plan:
- Reset then single block:
  - Stimulus: in_data=128'h637c777bf26b6fc53001672bfed7ab76, out_ready=1.
  - Required: out_data=128'h000102030405060708090a0b0c0d0e0f; out_valid rises exactly 7 cycles after acceptance and is high for 1 cycle.
- Boundary bytes:
  - Stimulus: lanes 8'h63, 8'h00, 8'h16, 8'hed, 8'h7c, rest 8'h63.
  - Required: outputs 8'h00, 8'h52, 8'hff, 8'h53, 8'h01, rest 8'h00.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises; in_valid held high with a new state.
  - Required: out_valid and out_data stable throughout, in_ready=0; after out_ready=1, handshake, IDLE, then the second state is accepted the following cycle.
- Exhaustive:
  - Stimulus: 16 blocks covering bytes 8'h00..8'hff across lanes.
  - Required: each result matches the inverse of the forward S-box table; sbox(invsbox(x))==x for all 256 values.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle at 3 edges after acceptance.
  - Required: next cycle IDLE, out_valid=0, out_data=0, in_ready=1; a fresh block then completes correctly.
- Back-to-back throughput:
  - Stimulus: 4 blocks with in_valid and out_ready held high.
  - Required: acceptances exactly 9 cycles apart; all 4 results correct and in order.
